// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response port shared by the fetch stage (master)
// and the instruction memory (slave).
interface fetch_stage_if #(
  parameter int unsigned WIDTH = 32
);
  logic             imem_req_valid;
  logic [WIDTH-1:0] imem_req_addr;
  logic             imem_req_ready;
  logic             imem_resp_valid;
  logic [WIDTH-1:0] imem_resp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps at most one request outstanding
// to instruction memory, buffers responses in a small FIFO and presents the
// head as {instruction, pc} to the decode pipeline register.
// Optional build macro FETCH_PERF_EN adds perf_fetched / perf_discarded counters.
module fetch_stage #(
  parameter int unsigned             REG_WIDTH   = 32,
  parameter logic [REG_WIDTH-1:0]    RESET_PC    = '0,
  parameter int unsigned             QUEUE_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  fetch_stage_if.master            imem,
  input  logic                     redirect_valid,
  input  logic [REG_WIDTH-1:0]     redirect_pc,
  input  logic                     stall,
  output logic                     d_valid,
  output logic [2*REG_WIDTH-1:0]   pipe_D_o
`ifdef FETCH_PERF_EN
  ,
  output logic [REG_WIDTH-1:0]     perf_fetched,
  output logic [REG_WIDTH-1:0]     perf_discarded
`endif
);

  localparam int unsigned AW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t                 state_q, state_d;
  logic [REG_WIDTH-1:0]   pc_q, pc_d;
  logic [REG_WIDTH-1:0]   req_pc_q, req_pc_d;
  logic [CW-1:0]          count_q, count_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [2*REG_WIDTH-1:0] mem_q [QUEUE_DEPTH];

  logic          pop, push, accept, drop, can_issue, inflight;
  logic [CW:0]   occupancy;
  logic          unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Handshake decode, credit check and request generation.
  always_comb begin
    d_valid   = (count_q != '0);
    pop       = d_valid & ~stall & ~redirect_valid;
    // Only a kept (S_WAIT) response will occupy a FIFO slot.
    inflight  = (state_q == S_WAIT);
    occupancy = (CW+1)'(count_q) + (CW+1)'(inflight) - (CW+1)'(pop);
    can_issue = occupancy < (CW+1)'(QUEUE_DEPTH);
    imem.imem_req_valid = ~rst & can_issue & ~redirect_valid &
                          ((state_q == S_FETCH) | imem.imem_resp_valid);
    imem.imem_req_addr  = pc_q;
    accept    = imem.imem_req_valid & imem.imem_req_ready;
    push      = (state_q == S_WAIT) & imem.imem_resp_valid & ~redirect_valid;
    drop      = (state_q != S_FETCH) & imem.imem_resp_valid &
                (redirect_valid | (state_q == S_DRAIN));
    pipe_D_o  = d_valid ? mem_q[rd_ptr_q] : '0;
  end

  // Next-state logic for PC, FSM and FIFO bookkeeping; redirect wins over all.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect_valid) begin
      pc_d     = {redirect_pc[REG_WIDTH-1:2], 2'b00};
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      state_d  = ((state_q == S_FETCH) || imem.imem_resp_valid) ? S_FETCH : S_DRAIN;
    end else begin
      if (accept) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + REG_WIDTH'(4);
        state_d  = S_WAIT;
      end else if ((state_q != S_FETCH) && imem.imem_resp_valid) begin
        state_d  = S_FETCH;
      end
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // FSM and control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // FIFO storage; contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= {imem.imem_resp_data, req_pc_q};
  end

`ifdef FETCH_PERF_EN
  logic [REG_WIDTH-1:0] perf_fetched_q, perf_fetched_d;
  logic [REG_WIDTH-1:0] perf_discarded_q, perf_discarded_d;

  // Performance counters: pushes, and dropped responses plus flushed entries.
  always_comb begin
    perf_fetched_d   = perf_fetched_q + REG_WIDTH'(push);
    perf_discarded_d = perf_discarded_q + REG_WIDTH'(drop) +
                       (redirect_valid ? REG_WIDTH'(count_q) : '0);
  end

  // Counter registers, wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q   <= '0;
      perf_discarded_q <= '0;
    end else begin
      perf_fetched_q   <= perf_fetched_d;
      perf_discarded_q <= perf_discarded_d;
    end
  end

  assign perf_fetched   = perf_fetched_q;
  assign perf_discarded = perf_discarded_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed phases with a scoreboard of expected
// {instruction, pc} entries popped by a monitor on every decode hand-off.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        d_valid;
  logic [63:0] pipe_D_o;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_discarded;
`endif

  fetch_stage_if #(.WIDTH(32)) imem ();

  fetch_stage #(
    .REG_WIDTH  (32),
    .RESET_PC   (32'h0000_0000),
    .QUEUE_DEPTH(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (imem.master),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .d_valid       (d_valid),
    .pipe_D_o      (pipe_D_o)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_discarded(perf_discarded)
`endif
  );

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  // Memory model: one pending request, delivered while resp_en is high.
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  logic        resp_en;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  assign imem.imem_resp_valid = pend & resp_en;
  assign imem.imem_resp_data  = instr_of(pend_addr);

  always @(posedge clk) begin
    if (imem.imem_req_valid && imem.imem_req_ready) begin
      pend      <= 1'b1;
      pend_addr <= imem.imem_req_addr;
    end else if (pend && resp_en) begin
      pend <= 1'b0;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every decode hand-off must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && d_valid && !stall && !redirect_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected got=%h required=<none>", pipe_D_o);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if (pipe_D_o !== e) begin
          bad++;
          $display("FAIL sb_entry got=%h required=%h", pipe_D_o, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%h required=%h", nm, got, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_q.push_back({instr_of(pc), pc});
  endtask

  task automatic apply_reset();
    cyc();
    rst = 1'b1; imem.imem_req_ready = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; resp_en = 1'b1;
    cyc();
    cyc();
  endtask

  task automatic drain(input string nm);
    repeat (4) cyc();
    #2;
    chk(nm, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; imem.imem_req_ready = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; resp_en = 1'b1;

    // Phase A: reset values, then back-to-back stream 0x0,0x4,0x8.
    apply_reset();
    #2;
    chk("rst_req_valid", 64'(imem.imem_req_valid), 64'd0);
    chk("rst_d_valid",   64'(d_valid), 64'd0);
    chk("rst_pipe",      pipe_D_o, 64'd0);
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
    cyc(); rst = 1'b0; imem.imem_req_ready = 1'b1; #2;
    chk("a_req0_valid", 64'(imem.imem_req_valid), 64'd1);
    chk("a_req0_addr",  64'(imem.imem_req_addr), 64'h0);
    chk("a_dv_c0",      64'(d_valid), 64'd0);
    cyc(); #2;
    chk("a_req1_addr",  64'(imem.imem_req_addr), 64'h4);
    chk("a_dv_c1",      64'(d_valid), 64'd0);
    cyc(); #2;
    chk("a_req2_addr",  64'(imem.imem_req_addr), 64'h8);
    chk("a_dv_c2",      64'(d_valid), 64'd1);
    cyc(); imem.imem_req_ready = 1'b0; #2;
    chk("a_dv_c3",      64'(d_valid), 64'd1);
    cyc(); #2;
    chk("a_dv_c4",      64'(d_valid), 64'd1);
    cyc(); #2;
    chk("a_dv_c5",      64'(d_valid), 64'd0);
    drain("a_sb_drain");

    // Phase B: stall fills FIFO to 4, requests stop, release drains in order.
    apply_reset();
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
    cyc(); rst = 1'b0; imem.imem_req_ready = 1'b1; stall = 1'b1;
    repeat (5) cyc();
    cyc(); #2;
    chk("b_full_req_valid", 64'(imem.imem_req_valid), 64'd0);
    chk("b_full_d_valid",   64'(d_valid), 64'd1);
    chk("b_head_pc",        64'(pipe_D_o[31:0]), 64'h0);
    cyc(); stall = 1'b0; imem.imem_req_ready = 1'b0; #2;
    chk("b_resume_valid",   64'(imem.imem_req_valid), 64'd1);
    chk("b_resume_addr",    64'(imem.imem_req_addr), 64'h10);
    drain("b_sb_drain");

    // Phase C: ready low for three cycles holds the address at 0x4.
    apply_reset();
    expect_pc(32'h0); expect_pc(32'h4);
    cyc(); rst = 1'b0; imem.imem_req_ready = 1'b1;
    cyc(); imem.imem_req_ready = 1'b0; #2;
    chk("c_hold1_valid", 64'(imem.imem_req_valid), 64'd1);
    chk("c_hold1_addr",  64'(imem.imem_req_addr), 64'h4);
    cyc(); #2;
    chk("c_hold2_addr",  64'(imem.imem_req_addr), 64'h4);
    cyc(); #2;
    chk("c_hold3_addr",  64'(imem.imem_req_addr), 64'h4);
    cyc(); imem.imem_req_ready = 1'b1; #2;
    chk("c_accept_addr", 64'(imem.imem_req_addr), 64'h4);
    cyc(); imem.imem_req_ready = 1'b0; #2;
    chk("c_next_addr",   64'(imem.imem_req_addr), 64'h8);
    drain("c_sb_drain");

    // Phase D: redirect to 0x103 with a request outstanding and one entry queued.
    apply_reset();
    expect_pc(32'h100);
    cyc(); rst = 1'b0; imem.imem_req_ready = 1'b1;
    cyc(); #2;
    chk("d_pre_addr", 64'(imem.imem_req_addr), 64'h4);
    cyc(); resp_en = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h103; #2;
    chk("d_redir_req_valid", 64'(imem.imem_req_valid), 64'd0);
    chk("d_redir_d_valid",   64'(d_valid), 64'd1);
    cyc(); redirect_valid = 1'b0; #2;
    chk("d_post_d_valid",    64'(d_valid), 64'd0);
    chk("d_drain_req_valid", 64'(imem.imem_req_valid), 64'd0);
`ifdef FETCH_PERF_EN
    chk("d_perf_disc1", 64'(perf_discarded), 64'd1);
`endif
    cyc(); resp_en = 1'b1; #2;
    chk("d_target_valid", 64'(imem.imem_req_valid), 64'd1);
    chk("d_target_addr",  64'(imem.imem_req_addr), 64'h100);
    cyc(); imem.imem_req_ready = 1'b0; #2;
`ifdef FETCH_PERF_EN
    chk("d_perf_disc2", 64'(perf_discarded), 64'd2);
    chk("d_perf_fetch", 64'(perf_fetched), 64'd1);
`endif
    drain("d_sb_drain");

    // Phase E: redirect coinciding with a response drops it.
    apply_reset();
    expect_pc(32'h200);
    cyc(); rst = 1'b0; imem.imem_req_ready = 1'b1;
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h200; #2;
    chk("e_redir_req_valid", 64'(imem.imem_req_valid), 64'd0);
    cyc(); redirect_valid = 1'b0; #2;
    chk("e_target_valid", 64'(imem.imem_req_valid), 64'd1);
    chk("e_target_addr",  64'(imem.imem_req_addr), 64'h200);
    chk("e_d_valid",      64'(d_valid), 64'd0);
`ifdef FETCH_PERF_EN
    chk("e_perf_disc", 64'(perf_discarded), 64'd1);
`endif
    cyc(); imem.imem_req_ready = 1'b0;
    drain("e_sb_drain");

    // Phase F: reset mid-run with 3 queued entries and a request outstanding.
    apply_reset();
    expect_pc(32'h0);
    cyc(); rst = 1'b0; imem.imem_req_ready = 1'b1; stall = 1'b1;
    cyc(); cyc(); cyc(); #2;
    chk("f_pre_d_valid", 64'(d_valid), 64'd1);
    cyc(); rst = 1'b1; imem.imem_req_ready = 1'b0; resp_en = 1'b0; #2;
    chk("f_rst_req_valid", 64'(imem.imem_req_valid), 64'd0);
    cyc(); rst = 1'b0; resp_en = 1'b1; imem.imem_req_ready = 1'b1; stall = 1'b0; #2;
    chk("f_d_valid",     64'(d_valid), 64'd0);
    chk("f_pipe",        pipe_D_o, 64'd0);
    chk("f_req_valid",   64'(imem.imem_req_valid), 64'd1);
    chk("f_req_addr",    64'(imem.imem_req_addr), 64'h0);
    cyc(); imem.imem_req_ready = 1'b0; #2;
    chk("f_late_ignored", 64'(d_valid), 64'd0);
    cyc(); #2;
    chk("f_first_dv",    64'(d_valid), 64'd1);
    drain("f_sb_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
